// File: rtl/stack_ram_ctrl.sv
// stack_ram_ctrl: LIFO stack controller in front of an external single-port RAM.
// Pushes complete in the accept cycle. Pops and peeks present the address in the
// accept cycle, capture the RAM read data in READ, and pulse rd_valid one cycle later.
module stack_ram_ctrl #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          err,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_PUSH  = 3'd1;
    localparam logic [2:0] CMD_POP   = 3'd2;
    localparam logic [2:0] CMD_TOP   = 3'd3;
    localparam logic [2:0] CMD_CLEAR = 3'd4;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [0:0]  state;
    logic [AW:0] count_nxt;
    logic [AW:0] count_m1;
    logic        accept;
    logic        is_read_cmd;
    logic        do_push;
    logic        do_read;
    logic        err_nxt;

    // Occupancy flags come straight from the count register, never from cmd.
    assign empty     = (count == '0);
    assign full      = (count == DEPTH);
    assign cmd_ready = (state == IDLE);
    assign count_m1  = count - (AW+1)'(1);

    // Command decode: accepted only in IDLE; NONE is not an acceptance.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        accept      = cmd_valid && cmd_ready && (cmd != CMD_NONE);
        is_read_cmd = (cmd == CMD_POP) || (cmd == CMD_TOP);
        do_push     = accept && (cmd == CMD_PUSH) && !full;
        do_read     = accept && is_read_cmd && !empty;
        err_nxt     = accept && (((cmd == CMD_PUSH) && full) ||
                                 (is_read_cmd && empty) ||
                                 (cmd > CMD_CLEAR));
        count_nxt   = count;
        if (do_push) begin
            count_nxt = count + (AW+1)'(1);
        end else if (do_read && (cmd == CMD_POP)) begin
            count_nxt = count_m1;
        end else if (accept && (cmd == CMD_CLEAR)) begin
            count_nxt = '0;
        end
    end

    // RAM port: write on push, address-only on pop/peek, all zero otherwise.
    always_comb begin
        ram_we    = do_push;
        ram_wdata = do_push ? cmd_data : '0;
        ram_addr  = '0;
        if (do_push) begin
            ram_addr = count[AW-1:0];
        end else if (do_read) begin
            ram_addr = count_m1[AW-1:0];
        end
    end

    // State, occupancy and result registers; reset aborts any read in flight.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            state    <= IDLE;
            count    <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= do_read ? READ : IDLE;
            count    <= count_nxt;
            err      <= err_nxt;
            rd_valid <= (state == READ);
            if (state == READ) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule
